// File: rtl/exc_sequencer.sv
// Commit-stage exception/interrupt sequencer: prioritises MEM exceptions and interrupts, flushes, redirects fetch.
// Define INT_SYNC_EN to pass int_i through a 2-flop synchroniser before masking.
module exc_sequencer #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter logic [31:0] GEN_OFFSET    = 32'h0000_0180,
  parameter logic [31:0] REFILL_OFFSET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_dslot_i,
  input  logic [7:0]  mem_flags_i,
  input  logic        mem_load_i,
  input  logic [31:0] mem_badva_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  input  logic        mtc0_we_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_data_i,
  input  logic        fetch_rdy_i,
  output logic [31:0] exc_type_o,
  output logic        tlbmiss_o,
  output logic        load_o,
  output logic [31:0] exc_addr_o,
  output logic        dslot_o,
  output logic [31:0] badva_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [4:0] CP0_EPC = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic             int_pend;
  logic [5:0]       int_src;
  logic             int_pend_next;

  logic [31:0] win_code;
  logic        win_tlb;
  logic        win_eret;
  logic        win_adel_if;
  logic [31:0] epc_fwd;
  logic [31:0] target;
  logic        trigger;

  // Status/Cause fields outside the interrupt mask and IE/EXL are not consulted here.
  logic unused_status_cause;
  assign unused_status_cause = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

`ifdef INT_SYNC_EN
  logic [5:0] int_s1;
  logic [5:0] int_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_s1 <= '0;
      int_s2 <= '0;
    end else begin
      int_s1 <= int_i;
      int_s2 <= int_s1;
    end
  end

  assign int_src = int_s2;
`else
  assign int_src = int_i;
`endif

  // Level-sensitive pending interrupt: any unmasked HW or SW line, globally enabled and not in EXL.
  assign int_pend_next = ((|(int_src & status_i[15:10])) | (|(cause_i[9:8] & status_i[9:8])))
                         & status_i[0] & ~status_i[1];

  // Fixed-priority winner selection among the interrupt and MEM-stage flags.
  always_comb begin
    win_code    = '0;
    win_tlb     = 1'b0;
    win_eret    = 1'b0;
    win_adel_if = 1'b0;
    if (int_pend) begin
      win_code = EXC_INT;
    end else if (mem_flags_i[7]) begin
      win_code    = EXC_ADEL;
      win_adel_if = 1'b1;
    end else if (mem_flags_i[6]) begin
      win_tlb = 1'b1;
    end else if (mem_flags_i[5]) begin
      win_code = EXC_RI;
    end else if (mem_flags_i[4]) begin
      win_code = EXC_OV;
    end else if (mem_flags_i[3]) begin
      win_code = EXC_SYS;
    end else if (mem_flags_i[2]) begin
      win_code = EXC_BP;
    end else if (mem_flags_i[0]) begin
      win_code = mem_load_i ? EXC_ADEL : EXC_ADES;
    end else if (mem_flags_i[1]) begin
      win_code = EXC_ERET;
      win_eret = 1'b1;
    end
  end

  // An MTC0 to EPC retiring in WB this cycle must be seen by a simultaneous ERET.
  assign epc_fwd = (mtc0_we_i && (mtc0_addr_i == CP0_EPC)) ? mtc0_data_i : epc_i;

  always_comb begin
    target = ebase_i + GEN_OFFSET;
    if (win_eret) begin
      target = epc_fwd;
    end else if (win_tlb && !status_i[1]) begin
      target = ebase_i + REFILL_OFFSET;
    end
  end

  assign trigger = mem_valid_i & (int_pend | (|mem_flags_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_cnt  <= '0;
      int_pend   <= 1'b0;
      exc_type_o <= '0;
      tlbmiss_o  <= 1'b0;
      load_o     <= 1'b0;
      exc_addr_o <= '0;
      dslot_o    <= 1'b0;
      badva_o    <= '0;
      flush_o    <= 1'b0;
      redirect_o <= 1'b0;
      new_pc_o   <= '0;
      busy_o     <= 1'b0;
    end else begin
      int_pend   <= int_pend_next;
      exc_type_o <= '0;
      tlbmiss_o  <= 1'b0;
      load_o     <= 1'b0;
      exc_addr_o <= '0;
      dslot_o    <= 1'b0;
      badva_o    <= '0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state      <= S_COMMIT;
            flush_cnt  <= FLUSH_LOAD;
            exc_type_o <= win_code;
            tlbmiss_o  <= win_tlb;
            load_o     <= mem_load_i;
            exc_addr_o <= mem_pc_i;
            dslot_o    <= mem_dslot_i;
            badva_o    <= win_adel_if ? mem_pc_i : mem_badva_i;
            new_pc_o   <= target;
            flush_o    <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        S_COMMIT, S_FLUSH: begin
          // The COMMIT cycle counts as the first flush cycle.
          if (flush_cnt == '0) begin
            state      <= S_REDIRECT;
            flush_o    <= 1'b0;
            redirect_o <= 1'b1;
          end else begin
            state     <= S_FLUSH;
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        S_REDIRECT: begin
          if (fetch_rdy_i) begin
            state      <= S_IDLE;
            redirect_o <= 1'b0;
            busy_o     <= 1'b0;
            new_pc_o   <= '0;
          end
        end
        default: begin
          state      <= S_IDLE;
          flush_o    <= 1'b0;
          redirect_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios plus randomized transactions against a priority-table model.
module tb_exc_sequencer;

  localparam int unsigned FLUSH_CYCLES = 2;
`ifdef INT_SYNC_EN
  localparam int INT_STAGES = 3;
`else
  localparam int INT_STAGES = 1;
`endif

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_dslot;
  logic [7:0]  mem_flags;
  logic        mem_load;
  logic [31:0] mem_badva;
  logic [5:0]  int_lines;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] ebase;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        fetch_rdy;
  logic [31:0] exc_type;
  logic        tlbmiss;
  logic        load;
  logic [31:0] exc_addr;
  logic        dslot;
  logic [31:0] badva;
  logic        flush;
  logic        redirect;
  logic [31:0] new_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exc_sequencer #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_dslot_i(mem_dslot),
    .mem_flags_i(mem_flags), .mem_load_i(mem_load), .mem_badva_i(mem_badva),
    .int_i(int_lines), .status_i(status), .cause_i(cause), .epc_i(epc), .ebase_i(ebase),
    .mtc0_we_i(mtc0_we), .mtc0_addr_i(mtc0_addr), .mtc0_data_i(mtc0_data),
    .fetch_rdy_i(fetch_rdy),
    .exc_type_o(exc_type), .tlbmiss_o(tlbmiss), .load_o(load), .exc_addr_o(exc_addr),
    .dslot_o(dslot), .badva_o(badva), .flush_o(flush), .redirect_o(redirect),
    .new_pc_o(new_pc), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_valid = 1'b0; mem_flags = '0; mem_pc = '0; mem_dslot = 1'b0;
    mem_load = 1'b0; mem_badva = '0; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_data = '0;
  endtask

  function automatic logic model_ip(input logic [5:0] il, input logic [31:0] st, input logic [31:0] ca);
    return ((|(il & st[15:10])) | (|(ca[9:8] & st[9:8]))) & st[0] & ~st[1];
  endfunction

  // Priority-table reference: interrupt first, then flags in commit order.
  function automatic void model_exc(input logic [7:0] flags, input logic ip, input logic ld,
                                    input logic [31:0] pc, input logic [31:0] bva_in,
                                    input logic [31:0] st, input logic [31:0] eb, input logic [31:0] epc_eff,
                                    output logic [31:0] code, output logic tlb,
                                    output logic [31:0] bva, output logic [31:0] tgt);
    int pri_bit [8];
    int win;
    pri_bit = '{7, 6, 5, 4, 3, 2, 0, 1};
    win = -1;
    code = 32'h0; tlb = 1'b0; bva = bva_in; tgt = eb + 32'h180;
    if (ip) begin
      code = 32'h1;
      return;
    end
    for (int k = 0; k < 8; k++) if (win < 0 && flags[pri_bit[k]]) win = pri_bit[k];
    case (win)
      7: begin code = 32'h4; bva = pc; end
      6: begin tlb = 1'b1; if (!st[1]) tgt = eb; end
      5: code = 32'ha;
      4: code = 32'hc;
      3: code = 32'h8;
      2: code = 32'h9;
      0: code = ld ? 32'h4 : 32'h5;
      1: begin code = 32'he; tgt = epc_eff; end
      default: ;
    endcase
  endfunction

  task automatic set_env(input logic [31:0] st, input logic [31:0] ca, input logic [5:0] il,
                         input logic [31:0] ep, input logic [31:0] eb);
    status = st; cause = ca; int_lines = il; epc = ep; ebase = eb;
    clear_mem();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL env_idle: busy=%b required 0 with mem_valid low", busy);
    end
  endtask

  // One exception from IDLE through COMMIT, FLUSH and REDIRECT back to IDLE.
  task automatic run_txn(input string tag, input logic [7:0] flags, input logic [31:0] pc,
                         input logic [31:0] bva_in, input logic ds, input logic ld,
                         input logic we, input logic [4:0] ma, input logic [31:0] md,
                         input int rdy_wait, input bit junk);
    logic [31:0] e_code, e_bva, e_tgt, epc_eff;
    logic        e_tlb, ip;
    ip = model_ip(int_lines, status, cause);
    epc_eff = (we && ma == 5'd14) ? md : epc;
    model_exc(flags, ip, ld, pc, bva_in, status, ebase, epc_eff, e_code, e_tlb, e_bva, e_tgt);

    mem_valid = 1'b1; mem_flags = flags; mem_pc = pc; mem_badva = bva_in;
    mem_dslot = ds; mem_load = ld; mtc0_we = we; mtc0_addr = ma; mtc0_data = md;
    step();
    clear_mem();

    checks++;
    if (exc_type !== e_code) begin
      errors++; $display("FAIL %s exc_type: got %h required %h", tag, exc_type, e_code);
    end
    checks++;
    if (tlbmiss !== e_tlb) begin
      errors++; $display("FAIL %s tlbmiss: got %b required %b", tag, tlbmiss, e_tlb);
    end
    checks++;
    if ({exc_addr, dslot, load} !== {pc, ds, ld}) begin
      errors++; $display("FAIL %s commit_info: got addr=%h dslot=%b load=%b required addr=%h dslot=%b load=%b",
                         tag, exc_addr, dslot, load, pc, ds, ld);
    end
    checks++;
    if (badva !== e_bva) begin
      errors++; $display("FAIL %s badva: got %h required %h", tag, badva, e_bva);
    end
    checks++;
    if ({flush, busy, redirect} !== 3'b110) begin
      errors++; $display("FAIL %s commit_ctrl: got flush/busy/redirect=%b required 110", tag, {flush, busy, redirect});
    end

    for (int i = 1; i < int'(FLUSH_CYCLES); i++) begin
      step();
      checks++;
      if ({flush, busy, redirect, tlbmiss, exc_type} !== {4'b1100, 32'h0}) begin
        errors++; $display("FAIL %s flush_cycle%0d: got flush/busy/redirect/tlb=%b code=%h required 1100 code=0",
                           tag, i, {flush, busy, redirect, tlbmiss}, exc_type);
      end
    end

    step();
    checks++;
    if ({flush, busy, redirect, exc_type, new_pc} !== {3'b011, 32'h0, e_tgt}) begin
      errors++; $display("FAIL %s redirect: got flush/busy/redirect=%b code=%h new_pc=%h required 011 code=0 new_pc=%h",
                         tag, {flush, busy, redirect}, exc_type, new_pc, e_tgt);
    end

    for (int i = 0; i < rdy_wait; i++) begin
      if (junk) begin
        mem_valid = 1'b1; mem_flags = 8'h08; mem_pc = 32'hdead_0000;
      end
      step();
      checks++;
      if ({busy, redirect, exc_type, new_pc} !== {2'b11, 32'h0, e_tgt}) begin
        errors++; $display("FAIL %s hold%0d: got busy/redirect=%b code=%h new_pc=%h required 11 code=0 new_pc=%h",
                           tag, i, {busy, redirect}, exc_type, new_pc, e_tgt);
      end
    end

    fetch_rdy = 1'b1;
    step();
    fetch_rdy = 1'b0;
    clear_mem();
    checks++;
    if ({flush, busy, redirect, tlbmiss, exc_type} !== {4'b0000, 32'h0}) begin
      errors++; $display("FAIL %s back_idle: got flush/busy/redirect/tlb=%b code=%h required 0000 code=0",
                         tag, {flush, busy, redirect, tlbmiss}, exc_type);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_rdy = 1'b1;
    mem_valid = 1'b1; mem_flags = 8'hff; mem_pc = 32'h1234_5678; mem_dslot = 1'b1;
    mem_load = 1'b1; mem_badva = 32'h1; int_lines = 6'h3f; status = 32'h0000_fc01;
    cause = '0; epc = '0; ebase = 32'h8000_0000; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_data = '0;
    step(); step();
    checks++;
    if ({exc_type, tlbmiss, load, dslot, flush, redirect, busy} !== 38'h0) begin
      errors++; $display("FAIL reset_ctrl: got code=%h tlb=%b load=%b dslot=%b flush=%b redirect=%b busy=%b required all 0",
                         exc_type, tlbmiss, load, dslot, flush, redirect, busy);
    end
    checks++;
    if ({exc_addr, badva, new_pc} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got addr=%h badva=%h new_pc=%h required 0", exc_addr, badva, new_pc);
    end
    clear_mem(); fetch_rdy = 1'b0; int_lines = '0; status = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_interrupt();
    set_env(32'h0000_0401, 32'h0, 6'h01, 32'h0, 32'h8000_0000);
    run_txn("int", 8'h00, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0);
    int_lines = '0;
  endtask

  task automatic test_int_latency();
    int n;
    bit seen;
    set_env(32'h0000_0401, 32'h0, 6'h00, 32'h0, 32'h8000_0000);
    mem_valid = 1'b1; mem_pc = 32'h8000_0400;
    int_lines = 6'h01;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      step();
      n++;
      if (exc_type === 32'h1) seen = 1;
    end
    clear_mem(); int_lines = '0;
    // int_pend stage(s) plus the registered COMMIT outputs.
    checks++;
    if (!seen || n != INT_STAGES + 1) begin
      errors++; $display("FAIL int_latency: got %0d cycles (seen=%0d) required %0d", n, seen, INT_STAGES + 1);
    end
    fetch_rdy = 1'b1;
    for (int i = 0; i < int'(FLUSH_CYCLES) + 4; i++) step();
    fetch_rdy = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL int_latency_drain: busy=%b required 0", busy);
    end
  endtask

  task automatic test_priority();
    set_env(32'h0, 32'h0, 6'h0, 32'h0, 32'h8000_0000);
    run_txn("ri_ov", 8'h30, 32'h8000_0200, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0);
    run_txn("ades", 8'h01, 32'h8000_0210, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1, 0);
    run_txn("adel_if", 8'hc4, 32'h8000_0221, 32'h0000_0777, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0);
  endtask

  task automatic test_tlbmiss();
    set_env(32'h0, 32'h0, 6'h0, 32'h0, 32'h8000_0000);
    run_txn("tlb_exl0", 8'h40, 32'h8000_0300, 32'h0040_1000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0);
    set_env(32'h0000_0002, 32'h0, 6'h0, 32'h0, 32'h8000_0000);
    run_txn("tlb_exl1", 8'h40, 32'h8000_0300, 32'h0040_1000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 0, 0);
  endtask

  task automatic test_eret_fwd();
    set_env(32'h0, 32'h0, 6'h0, 32'h8000_1111, 32'h8000_0000);
    run_txn("eret_fwd", 8'h02, 32'h8000_0400, 32'h0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h8000_3000, 0, 0);
    run_txn("eret_nofwd", 8'h02, 32'h8000_0404, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h8000_3000, 0, 0);
  endtask

  task automatic test_redirect_hold();
    set_env(32'h0, 32'h0, 6'h0, 32'h0, 32'hbfc0_0000);
    run_txn("hold", 8'h08, 32'h8000_0500, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4, 1);
  endtask

  task automatic test_back_to_back();
    set_env(32'h0, 32'h0, 6'h0, 32'h8000_7000, 32'h8000_0000);
    run_txn("b2b_a", 8'h04, 32'h8000_0600, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0);
    run_txn("b2b_b", 8'h02, 32'h8000_0604, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0);
  endtask

  task automatic test_rst_mid();
    set_env(32'h0, 32'h0, 6'h0, 32'h0, 32'h8000_0000);
    mem_valid = 1'b1; mem_flags = 8'h08; mem_pc = 32'h8000_0700;
    step();
    clear_mem();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({flush, redirect, busy, tlbmiss, exc_type} !== {4'b0000, 32'h0}) begin
      errors++; $display("FAIL rst_mid: got flush/redirect/busy/tlb=%b code=%h required 0000 code=0",
                         {flush, redirect, busy, tlbmiss}, exc_type);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({flush, redirect, busy, exc_type} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL rst_mid_after: got flush/redirect/busy=%b code=%h required 000 code=0",
                         {flush, redirect, busy}, exc_type);
    end
  endtask

  task automatic test_random();
    logic [31:0] st, ca, ep, eb, pc, bv, md;
    logic [7:0]  fl;
    logic [5:0]  il;
    logic [4:0]  ma;
    logic        ip;
    for (int it = 0; it < 40; it++) begin
      st = $urandom; ca = $urandom; il = 6'($urandom); ep = $urandom; eb = $urandom;
      set_env(st, ca, il, ep, eb);
      ip = model_ip(il, st, ca);
      case ($urandom_range(0, 3))
        0: fl = 8'h00;
        1: fl = 8'(1 << $urandom_range(0, 7));
        default: fl = 8'($urandom & $urandom);
      endcase
      pc = $urandom; bv = $urandom; md = $urandom;
      ma = ($urandom_range(0, 1) == 1) ? 5'd14 : 5'($urandom);
      if (!ip && fl == 8'h00) begin
        mem_valid = 1'b1; mem_pc = pc;
        step();
        clear_mem();
        checks++;
        if ({busy, flush, exc_type} !== {2'b00, 32'h0}) begin
          errors++; $display("FAIL rand%0d no_trigger: got busy/flush=%b code=%h required 00 code=0",
                             it, {busy, flush}, exc_type);
        end
      end else begin
        run_txn($sformatf("rand%0d", it), fl, pc, bv, 1'($urandom), 1'($urandom),
                1'($urandom), ma, md, $urandom_range(0, 3), 1'($urandom));
      end
    end
    int_lines = '0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_rdy = 1'b0;
    test_reset();
    test_interrupt();
    test_int_latency();
    test_priority();
    test_tlbmiss();
    test_eret_fwd();
    test_redirect_hold();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
